// File: rtl/alu_issue_ctrl.sv
// Initiator side of the 8-bit ALU operand/opcode interface: accepts one request, sequences the ALU bus reads, returns the result.
// Optional macro ALU_FLAGS_EN adds a registered rsp_flags[1:0] output (bit0 zero, bit1 divide-by-zero).
module alu_issue_ctrl #(
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] WIDE_MASK   = 16'h0180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_lo,
  output logic [7:0] rsp_hi,
  output logic       rsp_wide,
`ifdef ALU_FLAGS_EN
  output logic [1:0] rsp_flags,
`endif
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [7:0] alu_opcode,
  output logic       alu_en,
  input  logic [7:0] alu_data
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [2:0] {IDLE, EXEC, RD_LO, RD_HI, RESP} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] op_q;
  logic       wide_q;

`ifdef ALU_FLAGS_EN
  function automatic logic [1:0] flags_of(input logic [3:0] op, input logic [7:0] b,
                                          input logic zero);
    return {((op == 4'hB) || (op == 4'hC)) && (b == 8'h00), zero};
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      op_q       <= 4'd0;
      wide_q     <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_lo     <= 8'h00;
      rsp_hi     <= 8'h00;
      rsp_wide   <= 1'b0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_opcode <= 8'h00;
      alu_en     <= 1'b0;
`ifdef ALU_FLAGS_EN
      rsp_flags  <= 2'b00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q       <= req_op;
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_opcode <= {4'h0, req_op};
            wide_q     <= WIDE_MASK[req_op];
            rsp_wide   <= WIDE_MASK[req_op];
            rsp_hi     <= 8'h00;
            cnt        <= WAIT_LD;
            req_ready  <= 1'b0;
`ifdef ALU_FLAGS_EN
            rsp_flags  <= 2'b00;
`endif
            state      <= EXEC;
          end else begin
            req_ready <= 1'b1;
          end
        end
        // Operands are stable on the bus; give the ALU its settle time before enabling it
        EXEC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            alu_en <= 1'b1;
            state  <= RD_LO;
          end
        end
        RD_LO: begin
          rsp_lo <= alu_data;
          if (wide_q) begin
            alu_opcode <= 8'h08;
            state      <= RD_HI;
          end else begin
            alu_en    <= 1'b0;
            rsp_valid <= 1'b1;
`ifdef ALU_FLAGS_EN
            rsp_flags <= flags_of(op_q, alu_b, alu_data == 8'h00);
`endif
            state     <= RESP;
          end
        end
        // Restore the real opcode so a following carry-dependent op sees the right ALU state
        RD_HI: begin
          rsp_hi     <= alu_data;
          alu_en     <= 1'b0;
          alu_opcode <= {4'h0, op_q};
          rsp_valid  <= 1'b1;
`ifdef ALU_FLAGS_EN
          rsp_flags  <= flags_of(op_q, alu_b, (rsp_lo == 8'h00) && (alu_data == 8'h00));
`endif
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: transaction-timeline reference model checked every cycle, directed literal cases, random traffic.
// Build with +define+ALU_FLAGS_EN to also cover the flag output.
module tb_alu_issue_ctrl;

  localparam int W = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_op = 4'h0;
  logic [7:0] req_a = 8'h00, req_b = 8'h00;
  logic       rsp_ready = 1'b0;
  logic       req_ready, rsp_valid, rsp_wide, alu_en;
  logic [7:0] rsp_lo, rsp_hi, alu_a, alu_b, alu_opcode;
  logic [7:0] alu_data;
  logic [1:0] rsp_flags;

  // second instance with a longer settle time
  logic       x_rst = 1'b0;
  logic       x_req_valid = 1'b0;
  logic [3:0] x_req_op = 4'h0;
  logic [7:0] x_req_a = 8'h00, x_req_b = 8'h00;
  logic       x_rsp_ready = 1'b0;
  logic       x_req_ready, x_rsp_valid, x_rsp_wide, x_alu_en;
  logic [7:0] x_rsp_lo, x_rsp_hi, x_alu_a, x_alu_b, x_alu_opcode;
  logic [7:0] x_alu_data;
  logic [1:0] x_rsp_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU; 8'hA5 stands in for the floating bus when not enabled
  function automatic logic [7:0] alu_ref(input logic [7:0] opc, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (opc)
      8'h00: return a + b;
      8'h01: return a - b;
      8'h02: return a & b;
      8'h03: return a | b;
      8'h04: return a ^ b;
      8'h05: return ~a;
      8'h06: return a << 1;
      8'h07: return p[7:0];
      8'h08: return p[15:8];
      8'h09: return a >> 1;
      8'h0A: return b;
      8'h0B: return (b == 8'h00) ? 8'hFF : a / b;
      8'h0C: return (b == 8'h00) ? a : a % b;
      8'h0D: return a + b + 8'h01;
      default: return a ^ b ^ opc;
    endcase
  endfunction

  assign alu_data   = alu_en   ? alu_ref(alu_opcode, alu_a, alu_b)       : 8'hA5;
  assign x_alu_data = x_alu_en ? alu_ref(x_alu_opcode, x_alu_a, x_alu_b) : 8'hA5;

  alu_issue_ctrl #(.WAIT_CYCLES(W), .WIDE_MASK(16'h0180)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_wide(rsp_wide),
`ifdef ALU_FLAGS_EN
    .rsp_flags(rsp_flags),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_en(alu_en), .alu_data(alu_data)
  );

  alu_issue_ctrl #(.WAIT_CYCLES(3), .WIDE_MASK(16'h0180)) dut3 (
    .clk(clk), .rst(x_rst),
    .req_valid(x_req_valid), .req_ready(x_req_ready),
    .req_op(x_req_op), .req_a(x_req_a), .req_b(x_req_b),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready),
    .rsp_lo(x_rsp_lo), .rsp_hi(x_rsp_hi), .rsp_wide(x_rsp_wide),
`ifdef ALU_FLAGS_EN
    .rsp_flags(x_rsp_flags),
`endif
    .alu_a(x_alu_a), .alu_b(x_alu_b), .alu_opcode(x_alu_opcode),
    .alu_en(x_alu_en), .alu_data(x_alu_data)
  );

`ifndef ALU_FLAGS_EN
  assign rsp_flags   = 2'b00;
  assign x_rsp_flags = 2'b00;
`endif

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: one transaction timeline ----------------
  // k counts rising edges since the accept edge of the op in flight.
  bit         busy = 0;
  int         k = 0;
  logic [3:0] m_op = 4'h0;
  logic [7:0] m_a = 8'h00, m_b = 8'h00;
  bit         m_w = 0;
  logic       e_rdy = 0, e_vld = 0, e_wide = 0, e_en = 0;
  logic [7:0] e_lo = 0, e_hi = 0, e_a = 0, e_b = 0, e_opc = 0;
  logic [1:0] e_flags = 0;

  task automatic model_step();
    int lat;
    if (!rst) begin
      busy = 0; e_rdy = 0; e_vld = 0; e_wide = 0; e_en = 0;
      e_lo = 0; e_hi = 0; e_a = 0; e_b = 0; e_opc = 0; e_flags = 0;
    end else if (!busy) begin
      if (e_rdy && req_valid) begin
        busy = 1; k = 0;
        m_op = req_op; m_a = req_a; m_b = req_b;
        m_w = (req_op == 4'h7) || (req_op == 4'h8);
        e_rdy = 0; e_a = req_a; e_b = req_b; e_opc = {4'h0, req_op};
        e_wide = m_w; e_hi = 0; e_flags = 0;
      end else begin
        e_rdy = 1;
      end
    end else if (e_vld) begin
      if (rsp_ready) begin
        e_vld = 0; busy = 0; e_rdy = 1;
      end
    end else begin
      k++;
      lat = W + 1 + (m_w ? 1 : 0);
      e_en  = (k == W) || (m_w && k == W + 1);
      e_opc = (m_w && k == W + 1) ? 8'h08 : {4'h0, m_op};
      if (k == W + 1) e_lo = alu_ref({4'h0, m_op}, m_a, m_b);
      if (m_w && k == W + 2) e_hi = alu_ref(8'h08, m_a, m_b);
      if (k == lat) begin
        e_vld = 1;
        e_flags = {((m_op == 4'hB) || (m_op == 4'hC)) && (m_b == 8'h00),
                   (e_lo == 8'h00) && (!m_w || e_hi == 8'h00)};
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("req_ready", req_ready, e_rdy);
    chk("rsp_valid", rsp_valid, e_vld);
    chk("alu_en", alu_en, e_en);
    chk("alu_opcode", alu_opcode, e_opc);
    chk("alu_a", alu_a, e_a);
    chk("alu_b", alu_b, e_b);
    chk("rsp_wide", rsp_wide, e_wide);
    chk("rsp_hi", rsp_hi, e_hi);
    if (!rst || e_vld || k >= W + 1) chk("rsp_lo", rsp_lo, e_lo);
`ifdef ALU_FLAGS_EN
    if (!rst || e_vld) chk("rsp_flags", rsp_flags, e_flags);
`endif
  end

  // ---------------- directed transactions with literal expectations ----------------
  task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int lat, input logic [7:0] xlo, input logic [7:0] xhi,
                       input logic xw, input logic [1:0] xflags, input int hold);
    int n;
    rsp_ready = 0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("dir_req_ready", req_ready, 1'b1);
    req_valid = 1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 0; req_op = 4'($urandom); req_a = 8'($urandom); req_b = 8'($urandom);
    n = 0;
    while (!rsp_valid && n < 30) begin
      @(negedge clk); n++;
      if (xw && n == W + 1) begin
        chk("dir_rd_hi_opcode", alu_opcode, 8'h08);
        chk("dir_rd_hi_en", alu_en, 1'b1);
      end
    end
    chk("dir_latency", 16'(n), 16'(lat));
    chk("dir_rsp_lo", rsp_lo, xlo);
    chk("dir_rsp_hi", rsp_hi, xhi);
    chk("dir_rsp_wide", rsp_wide, xw);
`ifdef ALU_FLAGS_EN
    chk("dir_rsp_flags", rsp_flags, xflags);
`endif
    for (int i = 0; i < hold; i++) begin
      req_valid = (i == 0);
      @(negedge clk);
      chk("bp_rsp_valid", rsp_valid, 1'b1);
      chk("bp_rsp_lo", rsp_lo, xlo);
      chk("bp_rsp_hi", rsp_hi, xhi);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    req_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("dir_rsp_done", rsp_valid, 1'b0);
  endtask

  initial begin
    int n, en_cnt, first_en;
    rst = 0; x_rst = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_alu_opcode", alu_opcode, 8'h00);
    @(negedge clk);
    rst = 1; x_rst = 1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1'b1);

    do_op(4'h0, 8'h12, 8'h34, 2, 8'h46, 8'h00, 1'b0, 2'b00, 1);
    do_op(4'h7, 8'h10, 8'h20, 3, 8'h00, 8'h02, 1'b1, 2'b00, 5);
    do_op(4'hB, 8'h05, 8'h00, 2, 8'hFF, 8'h00, 1'b0, 2'b10, 1);
    do_op(4'h1, 8'h07, 8'h07, 2, 8'h00, 8'h00, 1'b0, 2'b01, 0);
    do_op(4'h8, 8'h30, 8'h10, 3, 8'h03, 8'h03, 1'b1, 2'b00, 2);
    do_op(4'hD, 8'h01, 8'h02, 2, 8'h04, 8'h00, 1'b0, 2'b00, 0);

    // reset while the op is settling
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1; req_op = 4'h1; req_a = 8'h09; req_b = 8'h02;
    @(negedge clk);
    req_valid = 0;
    chk("mid_accepted", req_ready, 1'b0);
    rst = 0;
    @(negedge clk);
    chk("mid_rsp_valid", rsp_valid, 1'b0);
    chk("mid_alu_en", alu_en, 1'b0);
    chk("mid_req_ready", req_ready, 1'b0);
    chk("mid_alu_a", alu_a, 8'h00);
    chk("mid_alu_opcode", alu_opcode, 8'h00);
    rst = 1;
    @(negedge clk);
    chk("mid_ready_back", req_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", rsp_valid, 1'b0);
    end

    // longer settle time on the second instance
    n = 0;
    while (!x_req_ready && n < 20) begin @(negedge clk); n++; end
    x_req_valid = 1; x_req_op = 4'h2; x_req_a = 8'hF0; x_req_b = 8'h3C;
    @(negedge clk);
    x_req_valid = 0; x_req_a = 8'h00;
    en_cnt = x_alu_en ? 1 : 0;
    first_en = x_alu_en ? 0 : -1;
    n = 0;
    while (!x_rsp_valid && n < 30) begin
      @(negedge clk); n++;
      if (x_alu_en) begin
        en_cnt++;
        if (first_en < 0) first_en = n;
      end
    end
    chk("w3_first_en", 16'(first_en), 16'd3);
    chk("w3_en_cycles", 16'(en_cnt), 16'd1);
    chk("w3_latency", 16'(n), 16'd4);
    chk("w3_rsp_lo", x_rsp_lo, 8'h30);
    chk("w3_alu_en_off", x_alu_en, 1'b0);
    x_rsp_ready = 1;
    @(negedge clk);
    x_rsp_ready = 0;
    chk("w3_rsp_done", x_rsp_valid, 1'b0);

    // random traffic, including occasional resets
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 99) != 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_op    = 4'($urandom);
      req_a     = 8'($urandom);
      req_b     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst = 1; req_valid = 0; rsp_ready = 1;
    repeat (8) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the 8-bit ALU operand/opcode interface. It accepts one operation request over a valid/ready handshake and latches the operands and opcode. It drives the ALU operand, opcode and output-enable lines, waits for the ALU to settle during the clock-low phase, then samples the ALU data bus: the low byte for every op, plus the high byte for multiply ops. It returns the result on a valid/ready response port and sits between the CPU control unit and the ALU.

Parameters:
WAIT_CYCLES, 1, settle cycles in EXEC before the first bus read (legal range 1..15)
WIDE_MASK, 16'h0180, bit n set means opcode n also needs a high-byte read (default: ops 0x7 and 0x8)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  controller idle and able to accept a request
req_op  in  4  ALU operation code
req_a  in  8  operand A
req_b  in  8  operand B
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_lo  out  8  result bits 7:0
rsp_hi  out  8  result bits 15:8; 0 for narrow ops
rsp_wide  out  1  rsp_hi is meaningful
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_opcode  out  8  ALU opcode; upper nibble always 0
alu_en  out  1  ALU output enable, active-high
alu_data  in  8  ALU data bus; floating (z) whenever alu_en is 0

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a rising edge): state goes to IDLE. All outputs become 0, including req_ready, rsp_valid, alu_en, alu_opcode, alu_a, alu_b, rsp_lo, rsp_hi and rsp_wide. The settle counter becomes 0.
- Reset mid-operation: the operation is abandoned with no response. alu_en is 0 after that edge. The first edge with rst=1 loads IDLE with req_ready=1.
- FSM states: IDLE, EXEC, RD_LO, RD_HI, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch op, a and b; drive alu_a/alu_b/alu_opcode={4'h0,op}; set wide=WIDE_MASK[op]; load counter=WAIT_CYCLES; clear rsp_hi; move to EXEC; req_ready=0.
- EXEC:
  - alu_en=0; operands and opcode held stable.
  - Counter decrements each cycle. When the counter equals 1, move to RD_LO and set alu_en=1.
- RD_LO:
  - alu_en=1; opcode is {4'h0,op}.
  - At the edge, rsp_lo<=alu_data.
  - If wide: next state RD_HI with alu_opcode<=8'h08. Otherwise: next state RESP with alu_en<=0.
- RD_HI:
  - alu_en=1; opcode is 8'h08.
  - At the edge, rsp_hi<=alu_data, alu_en<=0, alu_opcode<=op (restored so a following op 0xD reads the correct carry state), then move to RESP.
- RESP:
  - rsp_valid=1; rsp_lo/rsp_hi/rsp_wide are held.
  - On rsp_ready: rsp_valid<=0, move to IDLE, req_ready<=1.
- Latency from the accept edge to rsp_valid: WAIT_CYCLES+1 cycles for narrow ops, WAIT_CYCLES+2 for wide ops.
- Throughput: one op in flight. There is no acceptance in RESP; a new request is accepted earliest one cycle after the response handshake.
- Arithmetic: the controller performs no arithmetic; results are the ALU bus values verbatim. Ops 0xE and 0xF are forwarded unchanged, and the response carries whatever the ALU drives.
- Bus contention: alu_en is never 1 outside RD_LO and RD_HI.
- rsp_ready is ignored outside RESP.
- req_valid is ignored outside IDLE. Request fields are sampled only on the accept edge.

Optional Feature:
ALU_FLAGS_EN:
- Defined: adds output rsp_flags[1:0], registered and valid alongside rsp_valid, reset 0.
  - bit0 = zero: rsp_lo==0, and additionally rsp_hi==0 when wide.
  - bit1 = divzero: op is 0xB or 0xC with latched b==0.
- Undefined: the port is absent and no flag logic is present.

Test Plan:
- WAIT_CYCLES=1, accept op=0, a=0x12, b=0x34, ALU model attached -> rsp_valid 2 cycles after the accept edge; rsp_lo=0x46, rsp_hi=0x00, rsp_wide=0.
- Accept op=7, a=0x10, b=0x20 -> RD_HI drives alu_opcode=0x08; rsp_lo=0x00, rsp_hi=0x02, rsp_wide=1; rsp_valid 3 cycles after accept.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and result held constant; req_ready stays 0; a req_valid pulse in that window is not accepted.
- rst=0 for one cycle while in EXEC of op=1 -> next cycle all outputs are 0 and no rsp_valid ever appears; the cycle after reset deasserts, req_ready=1.
- WAIT_CYCLES=3, op=2, a=0xF0, b=0x3C -> alu_en stays 0 for 3 cycles after accept and is 1 for exactly 1 cycle; rsp_lo=0x30.
- ALU_FLAGS_EN defined, op=0xB, a=0x05, b=0x00 -> rsp_flags=2'b10 and rsp_lo equals the ALU bus value; op=1, a=b=0x07 -> rsp_flags=2'b01.
